// File: rtl/cpu_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and index-width helper.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        RESUME = 2'd2,
        STEP   = 2'd3
    } state_e;

    // Index width that stays legal for a single-entry table.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline/debug control bundle: hazard and redirect requests in, per-stage stall/flush out.
// Counter ports exist only when PIPELINE_CTRL_PERF_EN is defined.
interface pipeline_ctrl_if
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int BP_COUNT   = 4,
    parameter int ADDR_W     = 32
);

    localparam int STAGE_W  = $clog2(NUM_STAGES);
    localparam int BP_IDX_W = idx_w(BP_COUNT);

    logic                  hazard;
    logic                  redir_valid;
    logic [STAGE_W-1:0]    redir_stage;
    logic [ADDR_W-1:0]     fetch_pc;
    logic                  bp_wr_en;
    logic [BP_IDX_W-1:0]   bp_wr_idx;
    logic [ADDR_W-1:0]     bp_wr_addr;
    logic                  bp_wr_valid;
    logic                  continue_sig;
    logic                  step_sig;
    logic [NUM_STAGES-1:0] stall;
    logic [NUM_STAGES-1:0] flush;
    logic                  halted;
    logic [BP_IDX_W-1:0]   bp_hit_idx;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0]           cycle_cnt;
    logic [31:0]           stall_cnt;
`endif

    modport master (
        output hazard, redir_valid, redir_stage, fetch_pc,
        output bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid,
        output continue_sig, step_sig,
`ifdef PIPELINE_CTRL_PERF_EN
        input  cycle_cnt, stall_cnt,
`endif
        input  stall, flush, halted, bp_hit_idx
    );

    modport slave (
        input  hazard, redir_valid, redir_stage, fetch_pc,
        input  bp_wr_en, bp_wr_idx, bp_wr_addr, bp_wr_valid,
        input  continue_sig, step_sig,
`ifdef PIPELINE_CTRL_PERF_EN
        output cycle_cnt, stall_cnt,
`endif
        output stall, flush, halted, bp_hit_idx
    );

endinterface

// File: rtl/pipeline_ctrl_bp_match.sv
// PC breakpoint comparator table with lowest-index priority encoder.
// Writes land on the next edge; match output is combinational from the stored table.
module bp_match
    import cpu_pkg::*;
#(
    parameter  int BP_COUNT = 4,
    parameter  int ADDR_W   = 32,
    localparam int IDX_W    = idx_w(BP_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic              i_wr_valid,
    input  logic [ADDR_W-1:0] i_pc,
    output logic              o_hit,
    output logic [IDX_W-1:0]  o_idx
);

    logic [ADDR_W-1:0]   r_addr [BP_COUNT];
    logic [BP_COUNT-1:0] r_valid;
    logic                w_wr_ok;

    assign w_wr_ok = i_wr_en && (int'(i_wr_idx) < BP_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_wr_ok) begin
            r_valid[i_wr_idx] <= i_wr_valid;
        end
    end

    // Addresses are meaningless while their valid bit is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_addr[i_wr_idx] <= i_wr_addr;
        end
    end

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = BP_COUNT - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_addr[i] == i_pc)) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush control with PC breakpoints and halt/resume/step debug FSM.
// Stall/flush are combinational from inputs and state; optional counters under PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int HAZ_STAGE  = 1,
    parameter int BP_COUNT   = 4,
    parameter int ADDR_W     = 32
) (
    input  logic           clk,
    input  logic           rst,
    pipeline_ctrl_if.slave ctrl_if
);

    localparam int BP_IDX_W = idx_w(BP_COUNT);

    state_e                r_state;
    state_e                w_next;
    logic                  r_cont_q;
    logic                  r_step_q;
    logic                  r_bp_mask;
    logic [BP_IDX_W-1:0]   r_bp_hit_idx;
    logic                  w_match;
    logic [BP_IDX_W-1:0]   w_match_idx;
    logic                  w_bp_hit;
    logic                  w_cont_edge;
    logic                  w_step_edge;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_flush;
    logic                  w_halted;

    assign w_cont_edge = ctrl_if.continue_sig & ~r_cont_q;
    assign w_step_edge = ctrl_if.step_sig & ~r_step_q;

    bp_match #(
        .BP_COUNT (BP_COUNT),
        .ADDR_W   (ADDR_W)
    ) u_bp_match (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (ctrl_if.bp_wr_en),
        .i_wr_idx   (ctrl_if.bp_wr_idx),
        .i_wr_addr  (ctrl_if.bp_wr_addr),
        .i_wr_valid (ctrl_if.bp_wr_valid),
        .i_pc       (ctrl_if.fetch_pc),
        .o_hit      (w_match),
        .o_idx      (w_match_idx)
    );

    // A taken redirect squashes the fetched PC, so it can never be the breakpointed instruction.
    assign w_bp_hit = (r_state == RUN) & ~r_bp_mask & ~ctrl_if.redir_valid & w_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= RUN;
            r_cont_q     <= 1'b0;
            r_step_q     <= 1'b0;
            r_bp_mask    <= 1'b0;
            r_bp_hit_idx <= '0;
        end else begin
            r_state   <= w_next;
            r_cont_q  <= ctrl_if.continue_sig;
            r_step_q  <= ctrl_if.step_sig;
            r_bp_mask <= (r_state == RESUME);
            if (w_bp_hit) begin
                r_bp_hit_idx <= w_match_idx;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_stall  = '0;
        w_flush  = '0;
        w_halted = 1'b0;
        if (rst) begin
            w_flush = '1;
        end else begin
            unique case (r_state)
                RUN, STEP: begin
                    if (ctrl_if.redir_valid) begin
                        for (int i = 0; i < NUM_STAGES; i++) begin
                            w_flush[i] = (i < int'(ctrl_if.redir_stage));
                        end
                    end else if (ctrl_if.hazard) begin
                        for (int i = 0; i <= HAZ_STAGE; i++) begin
                            w_stall[i] = 1'b1;
                        end
                        w_flush[HAZ_STAGE] = 1'b1;
                    end
                    if (w_bp_hit) begin
                        w_stall[0] = 1'b1;
                        w_next     = HALT;
                    end
                    if (r_state == STEP) begin
                        w_next = HALT;
                    end
                end
                HALT: begin
                    w_stall  = '1;
                    w_halted = 1'b1;
                    if (w_cont_edge) begin
                        w_next = RESUME;
                    end else if (w_step_edge) begin
                        w_next = STEP;
                    end
                end
                RESUME: begin
                    w_stall = '1;
                    w_next  = RUN;
                end
                default: begin
                    w_next = RUN;
                end
            endcase
        end
    end

    assign ctrl_if.stall      = w_stall;
    assign ctrl_if.flush      = w_flush;
    assign ctrl_if.halted     = w_halted;
    assign ctrl_if.bp_hit_idx = r_bp_hit_idx;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (r_state != HALT) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_stall[0]) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign ctrl_if.cycle_cnt = r_cycle_cnt;
    assign ctrl_if.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized bench for pipeline_ctrl against a behavioural debug/pipeline model.
module tb_pipeline_ctrl;

    localparam int NS  = 5;
    localparam int HAZ = 1;
    localparam int BPC = 4;
    localparam int AW  = 32;

    logic clk;
    logic rst;

    pipeline_ctrl_if #(.NUM_STAGES(NS), .BP_COUNT(BPC), .ADDR_W(AW)) bus ();

    pipeline_ctrl #(
        .NUM_STAGES (NS),
        .HAZ_STAGE  (HAZ),
        .BP_COUNT   (BPC),
        .ADDR_W     (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: debug mode flags, breakpoint table, input history.
    logic [31:0] m_bp_addr [BPC];
    bit          m_bp_vld  [BPC];
    bit          m_halted, m_resume, m_stepping, m_skip;
    bit          m_prev_c, m_prev_s, m_known;
    int          m_hit_idx;

    // Inputs captured at evaluation time, applied to the model at the next edge.
    bit          p_rst, p_c, p_s, p_we, p_wv, p_hit;
    int          p_widx, p_hidx;
    logic [31:0] p_waddr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int bp_lookup(input logic [31:0] pc);
        for (int k = 0; k < BPC; k++) begin
            if (m_bp_vld[k] && m_bp_addr[k] == pc) return k;
        end
        return -1;
    endfunction

    function automatic bit running();
        return !m_halted && !m_resume && !m_stepping;
    endfunction

    function automatic bit hit_now();
        return running() && !m_skip && !bus.redir_valid && (bp_lookup(bus.fetch_pc) >= 0);
    endfunction

    task automatic eval();
        logic [4:0] e_stall;
        logic [4:0] e_flush;
        logic       e_halt;
        #1;
        e_stall = '0;
        e_flush = '0;
        e_halt  = 1'b0;
        if (rst) begin
            e_flush = 5'h1f;
        end else if (m_halted) begin
            e_stall = 5'h1f;
            e_halt  = 1'b1;
        end else if (m_resume) begin
            e_stall = 5'h1f;
        end else begin
            if (bus.redir_valid) begin
                e_flush = 5'((1 << bus.redir_stage) - 1);
            end else if (bus.hazard) begin
                e_stall = 5'((1 << (HAZ + 1)) - 1);
                e_flush = 5'(1 << HAZ);
            end
            if (hit_now()) e_stall[0] = 1'b1;
        end
        chk("stall", 32'(bus.stall), 32'(e_stall));
        chk("flush", 32'(bus.flush), 32'(e_flush));
        chk("halted", 32'(bus.halted), 32'(e_halt));
        if (m_known) chk("bp_hit_idx", 32'(bus.bp_hit_idx), m_hit_idx);
        p_rst   = rst;
        p_c     = bus.continue_sig;
        p_s     = bus.step_sig;
        p_we    = bus.bp_wr_en;
        p_widx  = int'(bus.bp_wr_idx);
        p_waddr = bus.bp_wr_addr;
        p_wv    = bus.bp_wr_valid;
        p_hit   = !rst && hit_now();
        p_hidx  = bp_lookup(bus.fetch_pc);
    endtask

    task automatic step_clk();
        bit ce;
        bit se;
        @(posedge clk);
        #1;
        if (p_rst) begin
            m_halted = 0; m_resume = 0; m_stepping = 0; m_skip = 0;
            m_prev_c = 0; m_prev_s = 0; m_hit_idx = 0; m_known = 1;
            for (int k = 0; k < BPC; k++) m_bp_vld[k] = 0;
        end else begin
            ce = p_c && !m_prev_c;
            se = p_s && !m_prev_s;
            if (m_halted) begin
                if (ce) begin
                    m_halted = 0; m_resume = 1;
                end else if (se) begin
                    m_halted = 0; m_stepping = 1;
                end
            end else if (m_resume) begin
                m_resume = 0; m_skip = 1;
            end else if (m_stepping) begin
                m_stepping = 0; m_halted = 1;
            end else begin
                m_skip = 0;
                if (p_hit) begin
                    m_halted = 1; m_hit_idx = p_hidx;
                end
            end
            if (p_we && p_widx < BPC) begin
                m_bp_addr[p_widx] = p_waddr;
                m_bp_vld[p_widx]  = p_wv;
            end
            m_prev_c = p_c;
            m_prev_s = p_s;
        end
    endtask

    initial begin
        int n_resume;
        rst              = 1'b1;
        bus.hazard       = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_stage  = '0;
        bus.fetch_pc     = '0;
        bus.bp_wr_en     = 1'b0;
        bus.bp_wr_idx    = '0;
        bus.bp_wr_addr   = '0;
        bus.bp_wr_valid  = 1'b0;
        bus.continue_sig = 1'b0;
        bus.step_sig     = 1'b0;

        // Reset cycle outputs
        eval();
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_flush", 32'(bus.flush), 32'h1f);
        step_clk();
        eval(); step_clk();
        rst = 1'b0;

        // Defaults after reset
        eval();
        chk("idle_stall", 32'(bus.stall), 32'h0);
        chk("idle_idx", 32'(bus.bp_hit_idx), 32'h0);
        step_clk();

        // Load-use hazard for two cycles
        bus.hazard = 1'b1;
        for (int k = 0; k < 2; k++) begin
            eval();
            chk("haz_stall", 32'(bus.stall), 32'h03);
            chk("haz_flush", 32'(bus.flush), 32'h02);
            step_clk();
        end
        bus.hazard = 1'b0;
        eval();
        chk("haz_off_stall", 32'(bus.stall), 32'h0);
        chk("haz_off_flush", 32'(bus.flush), 32'h0);
        step_clk();

        // Redirect from stage 3, with hazard also raised
        bus.redir_valid = 1'b1;
        bus.redir_stage = 3'd3;
        bus.hazard      = 1'b1;
        eval();
        chk("redir_flush", 32'(bus.flush), 32'h07);
        chk("redir_stall", 32'(bus.stall), 32'h0);
        step_clk();
        bus.redir_valid = 1'b0;
        bus.hazard      = 1'b0;

        // Breakpoint write is not visible in its own cycle
        bus.bp_wr_en    = 1'b1;
        bus.bp_wr_idx   = 2'd2;
        bus.bp_wr_addr  = 32'h40;
        bus.bp_wr_valid = 1'b1;
        bus.fetch_pc    = 32'h40;
        eval();
        chk("wr_same_cycle", 32'(bus.stall), 32'h0);
        step_clk();
        bus.bp_wr_en = 1'b0;

        // Breakpoint hit then halt
        eval();
        chk("hit_stall0", 32'(bus.stall), 32'h01);
        step_clk();
        bus.hazard      = 1'b1;
        bus.redir_valid = 1'b1;
        eval();
        chk("halt_halted", 32'(bus.halted), 32'h1);
        chk("halt_idx", 32'(bus.bp_hit_idx), 32'h2);
        chk("halt_stall", 32'(bus.stall), 32'h1f);
        chk("halt_flush", 32'(bus.flush), 32'h0);
        step_clk();
        bus.hazard      = 1'b0;
        bus.redir_valid = 1'b0;

        // Continue held high for 10 cycles
        bus.continue_sig = 1'b1;
        n_resume = 0;
        for (int k = 0; k < 10; k++) begin
            bus.fetch_pc = (k < 3) ? 32'h40 : 32'h44;
            eval();
            if (!bus.halted && bus.stall == 5'h1f) n_resume++;
            if (k == 0) chk("cont_still_halted", 32'(bus.halted), 32'h1);
            if (k == 1) chk("resume_stall", 32'(bus.stall), 32'h1f);
            if (k == 2) chk("run_masked_stall", 32'(bus.stall), 32'h0);
            if (k >= 2) chk("no_rehalt", 32'(bus.halted), 32'h0);
            step_clk();
        end
        chk("one_resume", n_resume, 1);
        bus.continue_sig = 1'b0;

        // Halt again, then single step
        bus.fetch_pc = 32'h40;
        eval(); step_clk();
        bus.step_sig = 1'b1;
        eval();
        chk("pre_step_halted", 32'(bus.halted), 32'h1);
        step_clk();
        bus.step_sig = 1'b0;
        eval();
        chk("step_stall", 32'(bus.stall), 32'h0);
        chk("step_halted", 32'(bus.halted), 32'h0);
        step_clk();
        eval();
        chk("post_step_halted", 32'(bus.halted), 32'h1);
        step_clk();

        // Leave halt
        bus.continue_sig = 1'b1;
        eval(); step_clk();
        bus.continue_sig = 1'b0;
        bus.fetch_pc     = 32'h48;
        eval(); step_clk();
        eval(); step_clk();

        // Breakpoint address with redirect in the same cycle
        bus.fetch_pc    = 32'h40;
        bus.redir_valid = 1'b1;
        bus.redir_stage = 3'd2;
        eval();
        chk("bp_redir_flush", 32'(bus.flush), 32'h03);
        chk("bp_redir_stall", 32'(bus.stall), 32'h0);
        step_clk();
        bus.redir_valid = 1'b0;
        bus.fetch_pc    = 32'h44;
        eval();
        chk("bp_redir_nohalt", 32'(bus.halted), 32'h0);
        step_clk();

        // Reset while halted
        bus.fetch_pc = 32'h40;
        eval(); step_clk();
        bus.fetch_pc = 32'h44;
        eval();
        chk("halt_before_rst", 32'(bus.halted), 32'h1);
        step_clk();
        rst = 1'b1;
        eval();
        chk("rst_in_halt_stall", 32'(bus.stall), 32'h0);
        chk("rst_in_halt_halted", 32'(bus.halted), 32'h0);
        step_clk();
        rst = 1'b0;
        bus.fetch_pc = 32'h40;
        eval();
        chk("after_rst_halted", 32'(bus.halted), 32'h0);
        chk("after_rst_bp_clear", 32'(bus.stall), 32'h0);
        step_clk();
        eval();
        chk("after_rst_nohalt", 32'(bus.halted), 32'h0);
        chk("after_rst_idx", 32'(bus.bp_hit_idx), 32'h0);
        step_clk();

        // Randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst             = ($urandom_range(99) == 0);
            bus.hazard      = ($urandom_range(3) == 0);
            bus.redir_valid = ($urandom_range(6) == 0);
            bus.redir_stage = 3'($urandom_range(NS - 1));
            case ($urandom_range(3))
                0:       bus.fetch_pc = 32'h40;
                1:       bus.fetch_pc = 32'h80;
                2:       bus.fetch_pc = 32'h100 + 32'($urandom_range(3)) * 4;
                default: bus.fetch_pc = $urandom;
            endcase
            bus.bp_wr_en    = ($urandom_range(11) == 0);
            bus.bp_wr_idx   = 2'($urandom_range(BPC - 1));
            case ($urandom_range(2))
                0:       bus.bp_wr_addr = 32'h40;
                1:       bus.bp_wr_addr = 32'h80;
                default: bus.bp_wr_addr = 32'h104;
            endcase
            bus.bp_wr_valid  = ($urandom_range(3) != 0);
            bus.continue_sig = ($urandom_range(7) == 0);
            bus.step_sig     = ($urandom_range(4) == 0);
            eval();
            step_clk();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 5, meaning the number of pipeline stages (min 3), where stage 0 is fetch.
REQ-002 SHALL have parameter HAZ_STAGE, default 1, meaning the stage that raises load-use hazards (1 ≤ HAZ_STAGE ≤ NUM_STAGES-2).
REQ-003 SHALL have parameter BP_COUNT, default 4, meaning the number of PC breakpoint comparators (1..16).
REQ-004 SHALL have parameter ADDR_W, default 32, meaning the PC width.
REQ-005 SHALL have ports: clk in 1 clock; rst in 1 reset (synchronous, active-high).
REQ-006 SHALL have ports: hazard in 1 load-use stall request; redir_valid in 1 branch/jump taken; redir_stage in $clog2(NUM_STAGES) index of the resolving stage.
REQ-007 SHALL have ports: fetch_pc in ADDR_W; bp_wr_en in 1; bp_wr_idx in $clog2(BP_COUNT); bp_wr_addr in ADDR_W; bp_wr_valid in 1.
REQ-008 SHALL have ports: continue_sig in 1 and step_sig in 1, both raw levels.
REQ-009 SHALL have outputs: stall out NUM_STAGES (hold stage-i output register); flush out NUM_STAGES (clear stage-i output register to a bubble); halted out 1; bp_hit_idx out $clog2(BP_COUNT).

Function
REQ-010 SHALL implement the states RUN, HALT, RESUME and STEP.
REQ-011 In RUN with redir_valid=1, SHALL drive flush[i]=1 for i<redir_stage and stall=0 in the same cycle (combinational).
REQ-012 In RUN with hazard=1 and no redirect, SHALL drive stall[0..HAZ_STAGE]=1 and flush[HAZ_STAGE]=1 (bubble into the next stage).
REQ-013 SHALL treat redir_valid and hazard together as redirect only.
REQ-014 SHALL declare a breakpoint hit in RUN when any valid comparator equals fetch_pc and redir_valid=0; the lowest matching index wins.
REQ-015 On a hit, SHALL drive stall[0]=1 in the same cycle, enter HALT on the next edge, and register bp_hit_idx.
REQ-016 In HALT, SHALL drive stall all-ones, flush zero, and halted=1.
REQ-017 SHALL ignore hazard and redir_valid while in HALT.
REQ-018 SHALL detect rising edges of continue_sig and step_sig using a 1-cycle history register; levels held high produce one event only.
REQ-019 In HALT, a continue edge SHALL move to RESUME; a step edge SHALL move to STEP; if both occur, continue wins.
REQ-020 In RESUME, SHALL keep stall all-ones for one cycle, then go to RUN with comparators masked for the first RUN cycle, so the breakpointed instruction is fetched.
REQ-021 In STEP, SHALL release all stages for exactly one cycle with comparators masked, then return to HALT.
REQ-022 In STEP, SHALL apply redirect/hazard rules as in RUN.
REQ-023 A bp_wr_en write SHALL take effect on the next cycle.
REQ-024 A same-cycle write to a matching index SHALL use the old value.

Reset
REQ-025 With rst=1 at a clk edge, SHALL enter RUN and clear all comparator valid bits, bp_hit_idx and the edge-history registers.
REQ-026 SHALL drive stall=0, flush=all-ones and halted=0 during the reset cycle.
REQ-027 Reset SHALL override any state, including HALT.

Configuration
REQ-028 With PIPELINE_CTRL_PERF_EN defined, SHALL add outputs cycle_cnt (32b, counts non-HALT cycles) and stall_cnt (32b, counts cycles with stall[0]=1 outside HALT).
REQ-029 Both counters SHALL wrap at 2^32 and clear on reset.
REQ-030 Without PIPELINE_CTRL_PERF_EN, SHALL have neither these ports nor their registers.

Structure
REQ-031 SHALL place the state encoding enum and the STATE_W constant in shared package cpu_pkg.
REQ-032 SHALL implement one sub-module, bp_match (comparator array plus priority encoder), instantiated once.

Verification
REQ-033 Bench SHALL cover: defaults, hazard=1 for 2 cycles -> stall=5'b00011 and flush=5'b00010 both cycles, then 0.
REQ-034 Bench SHALL cover: redir_valid=1, redir_stage=3 -> flush=5'b00111 and stall=0 that cycle.
REQ-035 Bench SHALL cover: bp[2]=0x40 valid, fetch_pc=0x40 -> stall[0]=1 that cycle; next cycle halted=1, bp_hit_idx=2, stall=5'b11111.
REQ-036 Bench SHALL cover: in HALT, continue_sig held high for 10 cycles -> one RESUME cycle, then RUN.
REQ-037 Bench SHALL cover the cycle after REQ-036's RUN entry: fetch_pc=0x40 -> no re-halt.
REQ-038 Bench SHALL cover: in HALT, step_sig pulse -> exactly one cycle with stall=0, then halted=1 again.
REQ-039 Bench SHALL cover: bp hit with redir_valid=1 same cycle -> no halt, flush applied.
REQ-040 Bench SHALL cover: rst asserted in HALT -> next cycle halted=0 and all bp valid bits cleared.
